// File: rtl/mem_if_pkg.sv
// Shared types and default sizing for the MAR/MDR memory-interface stage.
package mem_if_pkg;
   localparam int DATA_W_DEF         = 16;
   localparam int TIMEOUT_CYCLES_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/mem_wait_ctr.sv
// Saturating wait counter; term stays high once the count reaches TIMEOUT_CYCLES-1.
module mem_wait_ctr
   import mem_if_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic term
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign term = (count == LAST);
endmodule

// File: rtl/mar_mdr_mem_if.sv
// MAR/MDR owner and single-transaction req/ack sequencer toward external memory.
// Optional MEM_TIMEOUT_EN aborts a stalled transaction with err after TIMEOUT_CYCLES.
//
// state   | meaning
// IDLE    | accept MAR/MDR loads, wait for mem_start
// RD      | mem_rd asserted, waiting for ack (captures mem_rdata)
// WR      | mem_wr asserted, waiting for ack
// DONE    | one-cycle R pulse (err on timeout), back to IDLE
module mar_mdr_mem_if
   import mem_if_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              mem_start,
   input  logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              busy,
   output logic              R,
   output logic              err
);
   state_t state;
   logic   timeout;

`ifdef MEM_TIMEOUT_EN
   logic in_xfer;
   logic wait_term;

   assign in_xfer = (state == ST_RD) || (state == ST_WR);

   mem_wait_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_ctr (
      .clk  (Clk),
      .rst  (Reset),
      .clr  (!in_xfer),
      .en   (in_xfer),
      .term (wait_term)
   );

   // Ack on the terminal cycle wins, so timeout only fires without it.
   assign timeout = wait_term && !mem_ack;
`else
   wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout = 1'b0;
`endif

   // Outputs are registered from the next state, so they behave as Moore decodes.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= ST_IDLE;
         MAR    <= '0;
         MDR    <= '0;
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         busy   <= 1'b0;
         R      <= 1'b0;
         err    <= 1'b0;
      end else begin
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         busy   <= 1'b0;
         R      <= 1'b0;
         err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (LD_MAR) MAR <= bus_in;
               if (LD_MDR) MDR <= bus_in;
               if (mem_start) begin
                  busy <= 1'b1;
                  if (mem_we) begin
                     state  <= ST_WR;
                     mem_wr <= 1'b1;
                  end else begin
                     state  <= ST_RD;
                     mem_rd <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               if (mem_ack) begin
                  MDR   <= mem_rdata;
                  state <= ST_DONE;
                  R     <= 1'b1;
               end else if (timeout) begin
                  state <= ST_DONE;
                  R     <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  mem_rd <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            ST_WR: begin
               if (mem_ack) begin
                  state <= ST_DONE;
                  R     <= 1'b1;
               end else if (timeout) begin
                  state <= ST_DONE;
                  R     <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  mem_wr <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_addr  = MAR;
   assign mem_wdata = MDR;
endmodule

// File: tb/tb_mar_mdr_mem_if.sv
// Directed plus randomized transactions against a timeline model of the memory interface.
module tb_mar_mdr_mem_if;
   localparam int DW = 16;
   localparam int TC = 8;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic [DW-1:0] bus_in = '0;
   logic          LD_MAR = 1'b0;
   logic          LD_MDR = 1'b0;
   logic          mem_start = 1'b0;
   logic          mem_we = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] MAR, MDR, mem_addr, mem_wdata;
   logic          mem_rd, mem_wr, busy, R, err;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   logic [DW-1:0] m_mar = '0;
   logic [DW-1:0] m_mdr = '0;

   mar_mdr_mem_if #(.DATA_W(DW), .TIMEOUT_CYCLES(TC)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .bus_in    (bus_in),
      .LD_MAR    (LD_MAR),
      .LD_MDR    (LD_MDR),
      .mem_start (mem_start),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .MAR       (MAR),
      .MDR       (MDR),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .busy      (busy),
      .R         (R),
      .err       (err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Everything the block exposes when no transaction is running.
   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_rd"},   {31'd0, mem_rd}, 32'd0);
      chk({tag, "_wr"},   {31'd0, mem_wr}, 32'd0);
      chk({tag, "_R"},    {31'd0, R}, 32'd0);
      chk({tag, "_err"},  {31'd0, err}, 32'd0);
      chk({tag, "_mar"},  {16'd0, MAR}, {16'd0, m_mar});
      chk({tag, "_mdr"},  {16'd0, MDR}, {16'd0, m_mdr});
   endtask

   // One transaction: optional MDR preload, start with same-cycle LD_MAR, ack after 'delay'
   // extra cycles. Timeline: request visible for delay+1 cycles, then one R cycle, then idle.
   task automatic run_txn(input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic we, input int delay, input logic [DW-1:0] rdata,
                          input logic [DW-1:0] junk);
      if (we) begin
         bus_in = wdata; LD_MDR = 1'b1;
         tick();
         LD_MDR = 1'b0;
         m_mdr  = wdata;
      end
      bus_in = addr; LD_MAR = 1'b1; mem_start = 1'b1; mem_we = we;
      mem_ack = (delay == 0); mem_rdata = rdata;
      tick();
      m_mar = addr;
      LD_MAR = 1'b0; mem_start = 1'b0;
      for (int c = 0; c <= delay; c++) begin
         chk("xfer_busy", {31'd0, busy}, 32'd1);
         chk("xfer_rd",   {31'd0, mem_rd}, {31'd0, !we});
         chk("xfer_wr",   {31'd0, mem_wr}, {31'd0, we});
         chk("xfer_R",    {31'd0, R}, 32'd0);
         chk("xfer_err",  {31'd0, err}, 32'd0);
         chk("xfer_addr", {16'd0, mem_addr}, {16'd0, addr});
         chk("xfer_wdata", {16'd0, mem_wdata}, {16'd0, m_mdr});
         bus_in = junk; LD_MAR = 1'b1; LD_MDR = 1'b1;
         mem_ack = (c == delay);
         tick();
      end
      LD_MAR = 1'b0; LD_MDR = 1'b0; mem_ack = 1'b0;
      if (!we) m_mdr = rdata;
      chk("done_R",    {31'd0, R}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_rd",   {31'd0, mem_rd}, 32'd0);
      chk("done_wr",   {31'd0, mem_wr}, 32'd0);
      chk("done_err",  {31'd0, err}, 32'd0);
      chk("done_mdr",  {16'd0, MDR}, {16'd0, m_mdr});
      chk("done_mar",  {16'd0, MAR}, {16'd0, m_mar});
      mem_start = 1'b1; mem_we = ~we;
      tick();
      mem_start = 1'b0;
      chk_idle("after_done");
      tick();
      chk_idle("after_done2");
   endtask

   initial begin
      #2;
      chk_idle("reset");
      #5 Reset = 1'b0;
      tick();
      chk_idle("post_reset");

      // Reset mid-RD: outputs drop without a clock edge.
      bus_in = 16'h5A5A; LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
      bus_in = 16'h7777; LD_MAR = 1'b1; mem_start = 1'b1; mem_we = 1'b0; tick();
      LD_MAR = 1'b0; mem_start = 1'b0;
      tick();
      chk("midrd_rd_before", {31'd0, mem_rd}, 32'd1);
      #2 Reset = 1'b1;
      #1;
      m_mar = '0; m_mdr = '0;
      chk_idle("midrd_reset");
      #2 Reset = 1'b0;
      tick();
      chk_idle("midrd_released");

      run_txn(16'h3000, 16'h0000, 1'b0, 0, 16'hBEEF, 16'hFFFF);
      run_txn(16'h0042, 16'h1234, 1'b1, 3, 16'h0000, 16'hDEAD);
      run_txn(16'h00FF, 16'h0000, 1'b0, 1, 16'hC0DE, 16'h1111);

      for (int i = 0; i < 12; i++) begin
         run_txn(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
                 16'($urandom), 16'($urandom));
      end

`ifdef MEM_TIMEOUT_EN
      // Read with no ack: abort after TC cycles in RD, MDR keeps prior value.
      bus_in = 16'hAAAA; LD_MDR = 1'b1; tick(); LD_MDR = 1'b0; m_mdr = 16'hAAAA;
      bus_in = 16'h0100; LD_MAR = 1'b1; mem_start = 1'b1; mem_we = 1'b0; tick();
      LD_MAR = 1'b0; mem_start = 1'b0; m_mar = 16'h0100;
      for (int c = 0; c < TC; c++) begin
         chk("to_busy", {31'd0, busy}, 32'd1);
         chk("to_rd",   {31'd0, mem_rd}, 32'd1);
         tick();
      end
      chk("to_R",   {31'd0, R}, 32'd1);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_mdr", {16'd0, MDR}, 32'h0000AAAA);
      tick();
      chk_idle("to_after");
      run_txn(16'h0200, 16'h0000, 1'b0, TC - 1, 16'h5555, 16'h2222);
`else
      // No timeout: ack withheld 50 cycles keeps the request up.
      run_txn(16'h0300, 16'h0000, 1'b0, 50, 16'h6789, 16'h3333);
      run_txn(16'h0400, 16'h9876, 1'b1, 50, 16'h0000, 16'h4444);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
